uart_rx_os16: RTL

- 16x-oversampled UART receiver with per-frame error reporting and a single-entry holding register.
- The holding register has a valid/ready output handshake.
- Serves as the robust receive end for serial links driven by the team's UART transmitters; sits between the pad-side serial input and a byte consumer (FIFO or command parser).
- Adds majority-vote sampling, start-bit glitch rejection, parity/framing/overrun flags and break handling.

---
 rtl/uart_rx_os16.sv | 139 +++++++++++++
 1 files changed

// File: rtl/uart_rx_os16.sv
// 16x-oversampled UART receiver: majority-vote bit decisions, start glitch rejection,
// parity/framing/overrun reporting and a single-entry valid/ready holding register.
module uart_rx_os16 #(
  parameter logic [31:0] clk_freq_hz  = 32'd22118400,
  parameter logic [19:0] baudrate     = 20'd115200,
  parameter bit          sel_check    = 1'b1,
  parameter bit          parity_check = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx_i,
  input  logic       uart_rx_rdy_i,
  output logic       uart_rx_vld_o,
  output logic [7:0] uart_rx_data_o,
  output logic       uart_rx_perr_o,
  output logic       uart_rx_ferr_o,
  output logic       uart_rx_ovr_o,
  output logic       uart_rx_busy_o
);

  localparam int unsigned DIV   = clk_freq_hz / (32'(baudrate) * 32'd16);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t           state, state_nxt;
  logic             rx_meta, rxs, rxs_q;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       samp_cnt;
  logic             s7, s8;
  logic             tick, decide, maj;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             pbit;
  logic             frame_done, perr_calc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      rx_meta <= uart_rx_i;
      rxs     <= rx_meta;
      rxs_q   <= rxs;
    end
  end

  assign tick   = (div_cnt == DIV_W'(DIV - 1));
  assign decide = tick && (samp_cnt == 4'd8);
  assign maj    = (s7 & s8) | (s7 & rxs) | (s8 & rxs);

  // Counters sit at zero in IDLE so the first tick lands DIV clocks after the start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      samp_cnt <= '0;
      s7       <= 1'b1;
      s8       <= 1'b1;
    end else if (state == IDLE) begin
      div_cnt  <= '0;
      samp_cnt <= '0;
    end else if (tick) begin
      div_cnt  <= '0;
      samp_cnt <= samp_cnt + 4'd1;
      if (samp_cnt == 4'd6) s7 <= rxs;
      if (samp_cnt == 4'd7) s8 <= rxs;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (rxs_q && !rxs) state_nxt = START;
      START:   if (decide) state_nxt = maj ? IDLE : DATA;
      DATA:    if (decide && bit_idx == 3'd7) state_nxt = sel_check ? PARITY : STOP;
      PARITY:  if (decide) state_nxt = STOP;
      STOP:    if (decide) state_nxt = maj ? IDLE : BREAK;
      BREAK:   if (rxs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    uart_rx_busy_o = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx <= '0;
      shreg   <= '0;
      pbit    <= 1'b0;
    end else begin
      if (state == START) bit_idx <= '0;
      if (state == DATA && decide) begin
        shreg   <= {maj, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (state == PARITY && decide) pbit <= maj;
    end
  end

  assign frame_done = (state == STOP) && decide;
  assign perr_calc  = sel_check && ((^shreg ^ pbit) != parity_check);

  // A completion coinciding with a consumer accept replaces the held byte instead of overrunning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_rx_vld_o  <= 1'b0;
      uart_rx_data_o <= '0;
      uart_rx_perr_o <= 1'b0;
      uart_rx_ferr_o <= 1'b0;
      uart_rx_ovr_o  <= 1'b0;
    end else if (frame_done) begin
      if (!uart_rx_vld_o || uart_rx_rdy_i) begin
        uart_rx_vld_o  <= 1'b1;
        uart_rx_data_o <= shreg;
        uart_rx_perr_o <= perr_calc;
        uart_rx_ferr_o <= ~maj;
        uart_rx_ovr_o  <= 1'b0;
      end else begin
        uart_rx_ovr_o  <= 1'b1;
      end
    end else if (uart_rx_vld_o && uart_rx_rdy_i) begin
      uart_rx_vld_o  <= 1'b0;
      uart_rx_perr_o <= 1'b0;
      uart_rx_ferr_o <= 1'b0;
      uart_rx_ovr_o  <= 1'b0;
    end
  end

endmodule
